// File: rtl/bayer_demosaic_param.sv
// Parametrised 2x2 Bayer-to-RGB demosaic with its own line buffer and X/Y counters.
// Three-stage pipeline: accept + line-buffer read, window shift, colour select.
module bayer_demosaic_param #(
  parameter int DW    = 12,
  parameter int MAX_W = 1280,
  parameter int XW    = $clog2(MAX_W),
  parameter int YW    = 16
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [DW-1:0] iData,
  input  logic          iDval,
  input  logic          iSOF,
  input  logic [XW:0]   iWidth,
  input  logic [1:0]    iPattern,
  input  logic          iBypass,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic          oDval,
  output logic          oSOF,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY
);

  localparam logic [XW:0] MinW = (XW+1)'(2);
  localparam logic [XW:0] MaxW = (XW+1)'(MAX_W);

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  state_t stateReg, stateNext;
  logic   accept;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) stateReg <= WAIT_SOF;
    else      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    if (iDval && iSOF) stateNext = ACTIVE;
  end

  always_comb begin
    accept = iDval && (iSOF || stateReg == ACTIVE);
  end

  // An accepted SOF pixel sits at (0,0) and already obeys the freshly sampled config.
  logic [XW-1:0] xReg, curX;
  logic [YW-1:0] yReg, curY;
  logic [XW:0]   widthReg, clampW, curW;
  logic [1:0]    patReg, curPat;
  logic          bypReg, curByp, lastCol;

  always_comb begin
    clampW = iWidth;
    if (iWidth < MinW)      clampW = MinW;
    else if (iWidth > MaxW) clampW = MaxW;
    curX    = iSOF ? '0 : xReg;
    curY    = iSOF ? '0 : yReg;
    curW    = iSOF ? clampW : widthReg;
    curPat  = iSOF ? iPattern : patReg;
    curByp  = iSOF ? iBypass : bypReg;
    lastCol = ({1'b0, curX} == curW - (XW+1)'(1));
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      xReg     <= '0;
      yReg     <= '0;
      widthReg <= MinW;
      patReg   <= '0;
      bypReg   <= 1'b0;
    end else if (accept) begin
      if (iSOF) begin
        widthReg <= clampW;
        patReg   <= iPattern;
        bypReg   <= iBypass;
      end
      if (lastCol) begin
        xReg <= '0;
        yReg <= (curY == '1) ? curY : curY + YW'(1);
      end else begin
        xReg <= curX + XW'(1);
        yReg <= curY;
      end
    end
  end

  // Line buffer: read-before-write, so the read returns the previous row at this column.
  logic [DW-1:0] lineBuf [MAX_W];
  logic [DW-1:0] ramQ;

  always_ff @(posedge iCLK) begin
    if (accept) begin
      ramQ          <= lineBuf[curX];
      lineBuf[curX] <= iData;
    end
  end

  logic          v1, byp1;
  logic [DW-1:0] pix1;
  logic [XW-1:0] x1;
  logic [YW-1:0] y1;
  logic [1:0]    pat1;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v1   <= 1'b0;
      pix1 <= '0;
      x1   <= '0;
      y1   <= '0;
      pat1 <= '0;
      byp1 <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        pix1 <= iData;
        x1   <= curX;
        y1   <= curY;
        pat1 <= curPat;
        byp1 <= curByp;
      end
    end
  end

  // Window shifts only on accepted pixels so gaps leave it untouched.
  logic          v2, byp2;
  logic [DW-1:0] p00, p01, p10, p11;
  logic [XW-1:0] x2;
  logic [YW-1:0] y2;
  logic [1:0]    pat2;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v2   <= 1'b0;
      p00  <= '0;
      p01  <= '0;
      p10  <= '0;
      p11  <= '0;
      x2   <= '0;
      y2   <= '0;
      pat2 <= '0;
      byp2 <= 1'b0;
    end else begin
      v2 <= v1 && (byp1 || (x1 != '0 && y1 != '0));
      if (v1) begin
        p00  <= p01;
        p01  <= ramQ;
        p10  <= p11;
        p11  <= pix1;
        x2   <= x1;
        y2   <= y1;
        pat2 <= pat1;
        byp2 <= byp1;
      end
    end
  end

  logic [XW-1:0] oxC;
  logic [YW-1:0] oyC;
  logic [1:0]    phase;
  logic [DW:0]   sumA, sumB;
  logic [DW-1:0] redC, greenC, blueC;

  always_comb begin
    oxC   = byp2 ? x2 : x2 - XW'(1);
    oyC   = byp2 ? y2 : y2 - YW'(1);
    phase = pat2 ^ {oyC[0], oxC[0]};
    sumA  = {1'b0, p01} + {1'b0, p10};
    sumB  = {1'b0, p00} + {1'b0, p11};
    redC   = p00;
    greenC = DW'(sumA >> 1);
    blueC  = p11;
    case (phase)
      2'd1: begin redC = p01; blueC = p10; greenC = DW'(sumB >> 1); end
      2'd2: begin redC = p10; blueC = p01; greenC = DW'(sumB >> 1); end
      2'd3: begin redC = p11; blueC = p00; greenC = DW'(sumA >> 1); end
      default: ;
    endcase
    if (byp2) begin
      redC   = p11;
      greenC = p11;
      blueC  = p11;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDval  <= 1'b0;
      oSOF   <= 1'b0;
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oX     <= '0;
      oY     <= '0;
    end else begin
      oDval <= v2;
      oSOF  <= v2 && oxC == '0 && oyC == '0;
      if (v2) begin
        oRed   <= redC;
        oGreen <= greenC;
        oBlue  <= blueC;
        oX     <= oxC;
        oY     <= oyC;
      end
    end
  end

endmodule
